iob_nco_sweep: RTL and testbench



---
 rtl/iob_nco_sweep.sv | 188 ++++++++++++++++++
 tb/tb_iob_nco_sweep.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_nco_sweep.sv
// Frequency-sweep sequencer driving the NCO soft-reset, enable and period-write port.
// A latched configuration is stepped segment by segment from start to stop period, optionally looping.
module iob_nco_sweep #(
    parameter int PERIOD_W = 32,
    parameter int FRAC_W   = 8,
    parameter int DWELL_W  = 16
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                loop_i,
    input  logic [PERIOD_W-1:0] start_period_i,
    input  logic [PERIOD_W-1:0] stop_period_i,
    input  logic [PERIOD_W-1:0] step_i,
    input  logic [DWELL_W-1:0]  dwell_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                nco_soft_reset_o,
    output logic                nco_enable_o,
    output logic [PERIOD_W-1:0] nco_period_o,
    output logic                nco_period_wen_o
);

    // The period is fixed point, but only whole-word integer arithmetic is done here.
    if (FRAC_W >= PERIOD_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than PERIOD_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_DWELL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   start_q, start_d;
    logic [PERIOD_W-1:0]   stop_q, stop_d;
    logic [PERIOD_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  loop_q, loop_d;
    logic [PERIOD_W-1:0]   cur_q, cur_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  srst_q, srst_d;
    logic                  en_q, en_d;
    logic                  wen_q, wen_d;
    logic [PERIOD_W-1:0]   period_q, period_d;

    logic [PERIOD_W:0]     sum;
    logic                  step_neg;
    logic                  degenerate;
    logic                  last_seg;
    logic                  clamp;
    logic [PERIOD_W-1:0]   next_period;

    // Sum is one bit wider so that downward underflow shows up as a set sign bit.
    always_comb begin
        step_neg   = step_q[PERIOD_W-1];
        sum        = {1'b0, cur_q} + {step_q[PERIOD_W-1], step_q};
        degenerate = (step_q == '0) || (start_q == stop_q) ||
                     (!step_neg && (start_q > stop_q)) ||
                     (step_neg && (start_q < stop_q));
        last_seg   = (cur_q == stop_q) || degenerate;
        if (step_neg) begin
            clamp = sum[PERIOD_W] || (sum[PERIOD_W-1:0] <= stop_q);
        end else begin
            clamp = (sum >= {1'b0, stop_q});
        end
        next_period = clamp ? stop_q : sum[PERIOD_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_d = start_period_i;
                    stop_d  = stop_period_i;
                    step_d  = step_i;
                    dwell_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    loop_d  = loop_i;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                cur_d   = start_q;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d   = dwell_q;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                cnt_d = cnt_q - DWELL_W'(1);
                if (cnt_q <= DWELL_W'(1)) begin
                    if (!last_seg) begin
                        cur_d   = next_period;
                        state_d = S_LOAD;
                    end else if (loop_q) begin
                        cur_d   = start_q;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outranks any segment transition decided above.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cur_d   = cur_q;
            cnt_d   = cnt_q;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        srst_d   = (state_d == S_RST);
        en_d     = (state_d == S_LOAD) || (state_d == S_DWELL);
        wen_d    = (state_d == S_LOAD);
        period_d = (state_d == S_LOAD) ? cur_d : period_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            loop_q   <= 1'b0;
            cur_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            srst_q   <= 1'b0;
            en_q     <= 1'b0;
            wen_q    <= 1'b0;
            period_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            loop_q   <= loop_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            srst_q   <= srst_d;
            en_q     <= en_d;
            wen_q    <= wen_d;
            period_q <= period_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign nco_soft_reset_o = srst_q;
    assign nco_enable_o     = en_q;
    assign nco_period_wen_o = wen_q;
    assign nco_period_o     = period_q;

endmodule

// File: tb/tb_iob_nco_sweep.sv
// Scoreboard bench for iob_nco_sweep: expected NCO events are queued with their cycle,
// a monitor pops and compares every soft-reset, period write and done pulse.
module tb_iob_nco_sweep;
    localparam int W  = 32;
    localparam int DW = 16;
    localparam int K_SR   = 0;
    localparam int K_WEN  = 1;
    localparam int K_DONE = 2;

    logic          clk = 1'b0;
    logic          cke_i = 1'b1;
    logic          arst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [W-1:0]  start_period_i = '0;
    logic [W-1:0]  stop_period_i = '0;
    logic [W-1:0]  step_i = '0;
    logic [DW-1:0] dwell_i = '0;
    logic          busy_o, done_o, nco_soft_reset_o, nco_enable_o, nco_period_wen_o;
    logic [W-1:0]  nco_period_o;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  checks = 0;
    int  errors = 0;
    logic [36:0] snap;

    iob_nco_sweep dut (
        .clk_i            (clk),
        .cke_i            (cke_i),
        .arst_n_i         (arst_n_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .loop_i           (loop_i),
        .start_period_i   (start_period_i),
        .stop_period_i    (stop_period_i),
        .step_i           (step_i),
        .dwell_i          (dwell_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .nco_soft_reset_o (nco_soft_reset_o),
        .nco_enable_o     (nco_enable_o),
        .nco_period_o     (nco_period_o),
        .nco_period_wen_o (nco_period_wen_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [36:0] outs();
        return {busy_o, done_o, nco_soft_reset_o, nco_enable_o, nco_period_wen_o, nco_period_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc - t0);
        end else begin
            $display("check %s ok: %0h (cycle %0d)", name, act, cyc - t0);
        end
    endtask

    task automatic push(input int kind, input int off, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = t0 + off;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none",
                     kind, data, cyc - t0);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == K_WEN && e.data !== data)) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                         kind, data, cyc - t0, e.kind, e.data, e.cyc - t0);
            end else begin
                $display("event kind %0d data %0h at cycle %0d ok", kind, data, cyc - t0);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (nco_soft_reset_o) observe(K_SR, '0);
            if (nco_period_wen_o) observe(K_WEN, nco_period_o);
            if (done_o)           observe(K_DONE, '0);
        end
    endtask

    // Caller has already set t0 and queued expectations at this negedge.
    task automatic go(input logic [W-1:0] s, input logic [W-1:0] p, input logic [W-1:0] st,
                      input logic [DW-1:0] d, input logic lp);
        start_period_i = s;
        stop_period_i  = p;
        step_i         = st;
        dwell_i        = d;
        loop_i         = lp;
        start_i        = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle"}, 64'(busy_o), 64'd0);
        exp_q.delete();
    endtask

    task automatic push_up_writes();
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_WEN, 6, 32'h0B00);
        push(K_WEN, 10, 32'h0C00);
        push(K_WEN, 14, 32'h0D00);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        arst_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Up sweep
        t0 = cyc;
        push_up_writes();
        push(K_DONE, 18, '0);
        go(32'h0A00, 32'h0D00, 32'h0100, 16'd3, 1'b0);
        wait_to(t0 + 18);
        chk("up_busy_at_done", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("up_busy_after_done", 64'(busy_o), 64'd0);
        drain("up", 40);

        // Clamp at stop
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_WEN, 5, 32'h0B00);
        push(K_WEN, 8, 32'h0B80);
        push(K_DONE, 11, '0);
        go(32'h0A00, 32'h0B80, 32'h0100, 16'd2, 1'b0);
        drain("clamp", 40);

        // Down sweep
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0D00);
        push(K_WEN, 4, 32'h0C00);
        push(K_WEN, 6, 32'h0B00);
        push(K_WEN, 8, 32'h0A00);
        push(K_DONE, 10, '0);
        go(32'h0D00, 32'h0A00, 32'hFFFF_FF00, 16'd1, 1'b0);
        drain("down", 40);

        // Degenerate: zero step, dwell 0
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_DONE, 4, '0);
        go(32'h0A00, 32'h0D00, 32'h0, 16'd0, 1'b0);
        drain("step0", 20);

        // Degenerate: step points away from stop, dwell 0
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_DONE, 4, '0);
        go(32'h0A00, 32'h0800, 32'h0100, 16'd0, 1'b0);
        drain("wrongdir", 20);

        // Loop, ignored restart while busy, abort on the last DWELL cycle of pass two
        @(negedge clk);
        t0 = cyc;
        push_up_writes();
        push(K_WEN, 18, 32'h0A00);
        push(K_WEN, 22, 32'h0B00);
        go(32'h0A00, 32'h0D00, 32'h0100, 16'd3, 1'b1);
        wait_to(t0 + 8);
        start_period_i = 32'h1234;
        stop_period_i  = 32'h0;
        step_i         = 32'h0;
        loop_i         = 1'b0;
        start_i        = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_to(t0 + 25);
        chk("loop_enable_before_abort", 64'(nco_enable_o), 64'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_outputs", 64'(outs() & 37'h1F_0000_0000), 64'd0);
        drain("abort", 10);

        // Clock enable freeze during a DWELL
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_WEN, 6, 32'h0B00);
        push(K_WEN, 15, 32'h0C00);
        push(K_WEN, 19, 32'h0D00);
        push(K_DONE, 23, '0);
        go(32'h0A00, 32'h0D00, 32'h0100, 16'd3, 1'b0);
        wait_to(t0 + 8);
        cke_i = 1'b0;
        snap  = outs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("cke_frozen", 64'(outs()), 64'(snap));
        end
        cke_i = 1'b1;
        drain("cke", 40);

        // Asynchronous reset mid-DWELL, then a fresh sweep
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        go(32'h0A00, 32'h0D00, 32'h0100, 16'd3, 1'b0);
        wait_to(t0 + 4);
        arst_n_i = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        arst_n_i = 1'b1;
        drain("after_reset", 10);
        @(negedge clk);
        t0 = cyc;
        push(K_SR, 1, '0);
        push(K_WEN, 2, 32'h0A00);
        push(K_DONE, 4, '0);
        go(32'h0A00, 32'h0A00, 32'h0100, 16'd0, 1'b0);
        drain("recover", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
